// File: rtl/peak_result_avg_pkg.sv
// ----------------------------------------------------------------------------
// peak_result_avg_pkg
// Shared types and helpers for the peak result averager:
//   - state_t      : averager FSM states (ACCUM, DIV, MUL, OUT)
//   - sum_width()  : width of an accumulator holding 2^log2 samples
//   - cnt_width()  : width of the frame counter (must hold 2^log2 itself)
//   - DROP_CNT_MAX : saturation value of the dropped-frame counter
// ----------------------------------------------------------------------------
package peak_result_avg_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV   = 2'd1,
        MUL   = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [7:0] DROP_CNT_MAX = 8'd255;

    function automatic int unsigned sum_width(input int unsigned base_w,
                                              input int unsigned log2);
        return base_w + log2;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned log2);
        return log2 + 1;
    endfunction

endpackage

// File: rtl/peak_result_avg_if.sv
// ----------------------------------------------------------------------------
// peak_result_avg_if
// Result handshake between the averager and the display/UART stage.
//   m_valid : averaged result available          (master -> slave)
//   m_ready : consumer accepts the result        (slave  -> master)
//   m_amp   : averaged amplitude, AMP_WIDTH      (master -> slave)
//   m_bin   : averaged bin, ADDR_WIDTH           (master -> slave)
//   m_freq  : m_bin * BIN_HZ, FREQ_WIDTH         (master -> slave)
// ----------------------------------------------------------------------------
interface peak_result_avg_if #(
    parameter int unsigned AMP_WIDTH  = 25,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned FREQ_WIDTH = 32
) ();
    logic                  m_valid;
    logic                  m_ready;
    logic [AMP_WIDTH-1:0]  m_amp;
    logic [ADDR_WIDTH-1:0] m_bin;
    logic [FREQ_WIDTH-1:0] m_freq;

    modport master (output m_valid, output m_amp, output m_bin, output m_freq,
                    input  m_ready);
    modport slave  (input  m_valid, input  m_amp, input  m_bin, input  m_freq,
                    output m_ready);
endinterface

// File: rtl/peak_result_avg_rnd_shift.sv
// ----------------------------------------------------------------------------
// rnd_shift
// Round-half-up right shift: dout = (din + 2^(SHIFT-1)) >> SHIFT, or a plain
// copy when SHIFT = 0. din carries SHIFT extra headroom bits, so the rounded
// result always fits in WIDTH bits (max sum is 2^SHIFT*(2^WIDTH-1)).
//   din  : WIDTH+SHIFT-bit sum
//   dout : WIDTH-bit rounded quotient
// ----------------------------------------------------------------------------
module rnd_shift
    import peak_result_avg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHIFT = 0
) (
    input  logic [WIDTH+SHIFT-1:0] din,
    output logic [WIDTH-1:0]       dout
);
    generate
        if (SHIFT == 0) begin : g_copy
            assign dout = din;
        end else begin : g_round
            localparam logic [WIDTH+SHIFT-1:0] HALF = (WIDTH+SHIFT)'(1) << (SHIFT-1);
            logic [WIDTH+SHIFT-1:0] rsum;
            assign rsum = din + HALF;
            assign dout = WIDTH'(rsum >> SHIFT);
        end
    endgenerate
endmodule

// File: rtl/peak_result_avg.sv
// ----------------------------------------------------------------------------
// peak_result_avg
// Averages 2^AVG_LOG2 non-DC peak results (amplitude + bin), converts the
// averaged bin to Hz and holds the result on a valid/ready handshake. Frames
// arriving while a result is being formed or is pending are dropped and
// counted (saturating).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   root_valid  : one-cycle frame strobe
//   root_result : frame amplitude (AMP_WIDTH)
//   peak_addr   : frame peak bin (ADDR_WIDTH)
//   clear       : synchronous flush of sums and pending result, zeroes drop_cnt
//   m           : result handshake (peak_result_avg_if.master)
//   drop_cnt    : saturating dropped-frame count
// Build option: define PEAK_RESULT_AVG_FOLD_EN to fold mirror bins
// (bin >= 2^(ADDR_WIDTH-1) becomes 2^ADDR_WIDTH - bin) before use.
// ----------------------------------------------------------------------------
module peak_result_avg
    import peak_result_avg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned AMP_WIDTH  = 25,
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned BIN_HZ     = 1000,
    parameter int unsigned FREQ_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  root_valid,
    input  logic [AMP_WIDTH-1:0]  root_result,
    input  logic [ADDR_WIDTH-1:0] peak_addr,
    input  logic                  clear,
    peak_result_avg_if.master     m,
    output logic [7:0]            drop_cnt
);
    localparam int unsigned AMP_SUM_W = sum_width(AMP_WIDTH, AVG_LOG2);
    localparam int unsigned BIN_SUM_W = sum_width(ADDR_WIDTH, AVG_LOG2);
    localparam int unsigned CNT_W     = cnt_width(AVG_LOG2);
    localparam int unsigned PROD_W    = ADDR_WIDTH + 32;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    state_t                 state, state_nxt;
    logic [AMP_SUM_W-1:0]   amp_sum;
    logic [BIN_SUM_W-1:0]   bin_sum;
    logic [CNT_W-1:0]       frame_cnt;
    logic [ADDR_WIDTH-1:0]  bin_eff;
    logic [AMP_WIDTH-1:0]   amp_avg;
    logic [ADDR_WIDTH-1:0]  bin_avg;
    logic [PROD_W-1:0]      prod;
    logic                   acc_en, sum_clr, ld_avg, ld_freq, drop_ev;

`ifdef PEAK_RESULT_AVG_FOLD_EN
    assign bin_eff = peak_addr[ADDR_WIDTH-1] ? (~peak_addr + ADDR_WIDTH'(1)) : peak_addr;
`else
    assign bin_eff = peak_addr;
`endif

    rnd_shift #(.WIDTH(AMP_WIDTH),  .SHIFT(AVG_LOG2)) u_amp_shift (.din(amp_sum), .dout(amp_avg));
    rnd_shift #(.WIDTH(ADDR_WIDTH), .SHIFT(AVG_LOG2)) u_bin_shift (.din(bin_sum), .dout(bin_avg));

    // Product is taken from the m_bin registered in DIV.
    assign prod      = PROD_W'(m.m_bin) * PROD_W'(BIN_HZ);
    assign m.m_valid = (state == OUT);
    assign drop_ev   = root_valid && !clear && (state != ACCUM);

    always_comb begin
        state_nxt = state;
        acc_en    = 1'b0;
        sum_clr   = 1'b0;
        ld_avg    = 1'b0;
        ld_freq   = 1'b0;
        if (clear) begin
            state_nxt = ACCUM;
            sum_clr   = 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    // DC frames are discarded silently.
                    if (root_valid && (bin_eff != '0)) begin
                        acc_en = 1'b1;
                        if (frame_cnt == LAST_CNT) state_nxt = DIV;
                    end
                end
                DIV: begin
                    ld_avg    = 1'b1;
                    state_nxt = MUL;
                end
                MUL: begin
                    ld_freq   = 1'b1;
                    state_nxt = OUT;
                end
                OUT: begin
                    if (m.m_ready) begin
                        sum_clr   = 1'b1;
                        state_nxt = ACCUM;
                    end
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amp_sum   <= '0;
            bin_sum   <= '0;
            frame_cnt <= '0;
            m.m_amp   <= '0;
            m.m_bin   <= '0;
            m.m_freq  <= '0;
            drop_cnt  <= '0;
        end else begin
            if (sum_clr) begin
                amp_sum   <= '0;
                bin_sum   <= '0;
                frame_cnt <= '0;
            end else if (acc_en) begin
                amp_sum   <= amp_sum + AMP_SUM_W'(root_result);
                bin_sum   <= bin_sum + BIN_SUM_W'(bin_eff);
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (ld_avg) begin
                m.m_amp <= amp_avg;
                m.m_bin <= bin_avg;
            end
            if (ld_freq) begin
                m.m_freq <= FREQ_WIDTH'(prod);
            end
            if (clear) begin
                drop_cnt <= '0;
            end else if (drop_ev && (drop_cnt != DROP_CNT_MAX)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_peak_result_avg.sv
// ----------------------------------------------------------------------------
// tb_peak_result_avg
// Directed bench for peak_result_avg: u0 averages 8 frames, u1 averages a
// single frame (plain-copy path) and exercises mirror-bin folding.
// ----------------------------------------------------------------------------
module tb_peak_result_avg;

`ifdef PEAK_RESULT_AVG_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        root_valid;
    logic        rv1;
    logic        clear;
    logic [24:0] root_result;
    logic [10:0] peak_addr;
    logic [7:0]  drop0, drop1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    peak_result_avg_if #(.AMP_WIDTH(25), .ADDR_WIDTH(11), .FREQ_WIDTH(32)) m0 ();
    peak_result_avg_if #(.AMP_WIDTH(25), .ADDR_WIDTH(11), .FREQ_WIDTH(32)) m1 ();

    peak_result_avg #(.ADDR_WIDTH(11), .AMP_WIDTH(25), .AVG_LOG2(3),
                      .BIN_HZ(1000), .FREQ_WIDTH(32)) u0 (
        .clk(clk), .rst_n(rst_n), .root_valid(root_valid),
        .root_result(root_result), .peak_addr(peak_addr), .clear(clear),
        .m(m0), .drop_cnt(drop0));

    peak_result_avg #(.ADDR_WIDTH(11), .AMP_WIDTH(25), .AVG_LOG2(0),
                      .BIN_HZ(1000), .FREQ_WIDTH(32)) u1 (
        .clk(clk), .rst_n(rst_n), .root_valid(rv1),
        .root_result(root_result), .peak_addr(peak_addr), .clear(clear),
        .m(m1), .drop_cnt(drop1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [24:0] amp, input logic [10:0] bin);
        root_valid  = 1'b1;
        root_result = amp;
        peak_addr   = bin;
        step();
        root_valid  = 1'b0;
    endtask

    task automatic check_out0(input string tag, input logic [24:0] amp,
                              input logic [10:0] bin, input logic [31:0] freq);
        check({tag, "_amp"},  64'(m0.m_amp),  64'(amp));
        check({tag, "_bin"},  64'(m0.m_bin),  64'(bin));
        check({tag, "_freq"}, 64'(m0.m_freq), 64'(freq));
    endtask

    initial begin
        rst_n = 1'b0; root_valid = 1'b0; rv1 = 1'b0; clear = 1'b0;
        root_result = '0; peak_addr = '0;
        m0.m_ready = 1'b0; m1.m_ready = 1'b0;
        #12;
        // Reset state
        check("rst_valid", 64'(m0.m_valid), 64'd0);
        check_out0("rst", 25'd0, 11'd0, 32'd0);
        check("rst_drop", 64'(drop0), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Eight frames 100..107 at bin 50, back-to-back; latency c+3
        for (int i = 0; i < 8; i++) send(25'(100 + i), 11'd50);
        check("t2_valid_c1", 64'(m0.m_valid), 64'd0);
        step();
        check("t2_valid_c2", 64'(m0.m_valid), 64'd0);
        step();
        check("t2_valid_c3", 64'(m0.m_valid), 64'd1);
        check_out0("t2", 25'd104, 11'd50, 32'd50000);
        step();
        check("t2_hold", 64'(m0.m_valid), 64'd1);
        m0.m_ready = 1'b1;
        step();
        m0.m_ready = 1'b0;
        check("t2_after_hs", 64'(m0.m_valid), 64'd0);
        check("t2_keep_amp", 64'(m0.m_amp), 64'd104);

        // DC frame between valid frames is not counted
        for (int i = 1; i <= 4; i++) send(25'd1000, 11'(i));
        send(25'd99999, 11'd0);
        for (int i = 5; i <= 7; i++) send(25'd1000, 11'(i));
        step(); step(); step();
        check("t3_no_early", 64'(m0.m_valid), 64'd0);
        send(25'd1000, 11'd8);
        step(); step();
        check("t3_valid", 64'(m0.m_valid), 64'd1);
        check_out0("t3", 25'd1000, 11'd5, 32'd5000);
        check("t3_drop0", 64'(drop0), 64'd0);

        // 300 frames while result pending: dropped, saturating count, outputs stable
        for (int i = 0; i < 300; i++) send(25'(i + 7), 11'(i + 3));
        check("t4_valid", 64'(m0.m_valid), 64'd1);
        check_out0("t4_stable", 25'd1000, 11'd5, 32'd5000);
        check("t4_drop_sat", 64'(drop0), 64'd255);
        // clear wins over root_valid and m_ready in the same cycle
        clear = 1'b1; root_valid = 1'b1; m0.m_ready = 1'b1;
        step();
        clear = 1'b0; root_valid = 1'b0; m0.m_ready = 1'b0;
        check("t4_clr_valid", 64'(m0.m_valid), 64'd0);
        check("t4_clr_drop", 64'(drop0), 64'd0);
        check_out0("t4_clr_keep", 25'd1000, 11'd5, 32'd5000);

        // Max amplitude, m_ready held high: m_valid high for exactly one cycle
        m0.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(25'h1FF_FFFF, 11'd1023);
        check("t5_valid_c1", 64'(m0.m_valid), 64'd0);
        step(); step();
        check("t5_valid_c3", 64'(m0.m_valid), 64'd1);
        check_out0("t5", 25'h1FF_FFFF, 11'd1023, 32'd1023000);
        step();
        check("t5_valid_c4", 64'(m0.m_valid), 64'd0);
        m0.m_ready = 1'b0;

        // Reset mid-average: five frames then async reset
        for (int i = 0; i < 5; i++) send(25'd5000, 11'd300);
        rst_n = 1'b0;
        #2;
        check("t6_rst_valid", 64'(m0.m_valid), 64'd0);
        check_out0("t6_rst", 25'd0, 11'd0, 32'd0);
        check("t6_rst_drop", 64'(drop0), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 7; i++) send(25'(200 + i), 11'd100);
        step(); step(); step();
        check("t6_no_early", 64'(m0.m_valid), 64'd0);
        send(25'd207, 11'd100);
        step(); step();
        check("t6_valid", 64'(m0.m_valid), 64'd1);
        check_out0("t6", 25'd204, 11'd100, 32'd100000);

        // Single-frame average on u1 with a mirror bin
        rv1 = 1'b1; root_result = 25'd77; peak_addr = 11'd2000;
        step();
        rv1 = 1'b0;
        step(); step();
        check("t7_valid", 64'(m1.m_valid), 64'd1);
        check("t7_amp", 64'(m1.m_amp), 64'd77);
        check("t7_bin", 64'(m1.m_bin), FOLD ? 64'd48 : 64'd2000);
        check("t7_freq", 64'(m1.m_freq), FOLD ? 64'd48000 : 64'd2000000);
        check("t7_drop", 64'(drop1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/peak_result_avg.md
# peak_result_avg

Downstream of the FFT/CORDIC amplitude-and-peak pipeline. Each frame it takes one peak result: the root amplitude and the peak bin address. It averages 2^AVG_LOG2 accepted frames, converts the averaged bin into a frequency in Hz, and holds the result behind a valid/ready handshake for the display/UART stage. Frames that arrive while a result is pending are dropped and counted.

## Interface
Parameters:
- ADDR_WIDTH, 11: peak bin address width (2048-point FFT).
- AMP_WIDTH, 25: root amplitude width (CORDIC root output).
- AVG_LOG2, 3: log2 of frames averaged; 0..6 legal.
- BIN_HZ, 1000: integer Hz per FFT bin.
- FREQ_WIDTH, 32: frequency output width.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- root_valid, in, 1: one-cycle pulse, one per FFT frame.
- root_result, in, AMP_WIDTH: unsigned amplitude; sampled only when root_valid=1.
- peak_addr, in, ADDR_WIDTH: peak bin; sampled only when root_valid=1.
- clear, in, 1: synchronous flush of the accumulators and any pending result.
- m_valid, out, 1: averaged result available.
- m_ready, in, 1: consumer accepts the result.
- m_amp, out, AMP_WIDTH: averaged amplitude.
- m_bin, out, ADDR_WIDTH: averaged (folded) bin.
- m_freq, out, FREQ_WIDTH: m_bin*BIN_HZ, truncated to FREQ_WIDTH.
- drop_cnt, out, 8: saturating count of dropped frames.

## Operation
- FSM states:
  - ACCUM: wait for frames and accumulate.
  - DIV: form the averages.
  - MUL: form the frequency.
  - OUT: hold the result until accepted.
- ACCUM, on root_valid:
  - If the effective bin is 0 (DC), discard the frame; it is not counted and not a drop.
  - Otherwise add the amplitude to amp_sum (AMP_WIDTH+AVG_LOG2 bits) and the bin to bin_sum (ADDR_WIDTH+AVG_LOG2 bits), and increment frame_cnt.
  - When frame_cnt reaches 2^AVG_LOG2 → DIV.
- DIV: round-half-up shift, m_amp=(amp_sum+2^(AVG_LOG2-1))>>AVG_LOG2, m_bin likewise; for AVG_LOG2=0 it is a plain copy. This never overflows. → MUL.
- MUL: register m_freq. → OUT.
- OUT: m_valid=1; outputs stay stable until m_valid&&m_ready. On that transfer: clear sums and frame_cnt, m_valid=0 next cycle, → ACCUM.
- root_valid in DIV, MUL or OUT, including the handshake cycle, is a drop: drop_cnt+1, saturating at 255.
- clear: → ACCUM, zero sums and frame_cnt, m_valid=0 next cycle, m_amp/m_bin/m_freq keep their last values, drop_cnt=0.
  - clear beats root_valid and m_ready in the same cycle; that frame is neither accumulated nor counted as a drop.
- rst_n low, at any time including mid-average: every register goes to 0 immediately.
  - m_valid=0, m_amp=0, m_bin=0, m_freq=0, drop_cnt=0, state ACCUM.

## Timing
- Let c be the cycle root_valid delivers the final frame of the average. DIV runs at c+1, MUL at c+2, m_valid=1 from c+3.
- Minimum spacing between results is 2^AVG_LOG2 frames + 3 cycles + the handshake cycle.
- Back-to-back root_valid on consecutive cycles in ACCUM is supported: one accumulate per cycle.
- m_ready may be held high permanently: m_valid is high for exactly one cycle, at c+3.
- The multiplier is one registered stage, and the product is taken from m_bin already registered in DIV.

## Configuration
- PEAK_RESULT_AVG_FOLD_EN defined: a bin ≥ 2^(ADDR_WIDTH-1) is replaced by 2^ADDR_WIDTH−bin before the DC check and accumulation. This removes real-input FFT mirror peaks.
- Undefined: the bin is used raw, so mirror bins are averaged as-is.

## Structure
- Package peak_result_avg_pkg holds:
  - the state enum (ACCUM, DIV, MUL, OUT);
  - localparam width helpers for the sum widths;
  - DROP_CNT_MAX=255.
- One sub-module, rnd_shift, parameterised width/shift and doing the round-half-up right shift, is instantiated twice (amp, bin).
- Everything else is in the top module.

## Test plan
- AVG_LOG2=3, eight frames of amp 100..107, bin 50 → m_amp=104, m_bin=50, m_freq=50000, m_valid rises 3 cycles after the 8th root_valid.
- FOLD_EN, AVG_LOG2=0, bin 2000 → m_bin=48, m_freq=48000; without FOLD_EN → m_bin=2000, m_freq=2000000.
- Frame with bin 0 between valid frames → not counted; the result needs 8 non-DC frames.
- m_ready low, 300 frames during OUT → outputs stable, drop_cnt saturates at 255; clear → drop_cnt=0, m_valid=0, state ACCUM.
- rst_n low after 5 of 8 frames, then release plus 8 frames → output is the average of only the last 8 frames, all outputs 0 during reset.
- Max amplitude 2^25−1 on all frames → m_amp=2^25−1, no wrap.
